rv_mc_core: RTL and testbench
=============================

Name: rv_mc_core

Overview:
Multi-cycle RV integer core that replaces the single-cycle datapath.
- Fetches instructions over a valid/ready request + response-valid memory interface instead of a combinational instruction input.
- Executes a small RV subset from an internal register file.
- Retires at most one instruction per EXEC cycle.
- Reports halt (ebreak, illegal opcode, misaligned target) as registered outputs. The surrounding top turns these into DPI calls.

Parameters:
XLEN, 64, datapath/register/PC width (32 or 64)
NREGS, 32, architectural registers (32 for RV-I, 16 for RV-E); rd/rs index >= NREGS is illegal
RESET_PC, 64'h8000_0000, PC after reset (truncated to XLEN)
CNT_W, 64, width of retired-instruction counter

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous, active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address (= pc)
imem_rsp_valid  in  1  instruction word valid
imem_rsp_data  in  32  instruction word
retire_valid  out  1  one-cycle pulse per retired instruction
retire_pc  out  XLEN  PC of retired instruction
instret  out  CNT_W  retired-instruction count
halted  out  1  core stopped
halt_cause  out  2  0 none, 1 ebreak, 2 illegal, 3 misaligned
halt_pc  out  XLEN  PC of the halting instruction
exit_value  out  XLEN  x10 (a0) at halt

Behaviour:
- Reset (rst=0, async):
  - state=FETCH, pc=RESET_PC, all registers 0.
  - retire_valid=0, retire_pc=0, instret=0, halted=0, halt_cause=0, halt_pc=0, exit_value=0.
  - Takes effect in any state, including mid-fetch. An outstanding response arriving after reset while in FETCH is ignored.
- FETCH:
  - imem_req_valid=1, imem_req_addr=pc.
  - req_valid stays high and addr stays stable until req_ready. Then go to WAIT.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid, latch imem_rsp_data into the inst register and go to EXEC. No timeout.
  - rsp_valid in any other state is ignored.
- EXEC (one cycle): decode inst, read rs1/rs2, compute, then update state.
  - ADDI, ADD, SUB, LUI, AUIPC, JAL, JALR: write rd (suppressed if rd==0; x0 always reads 0).
    - next pc = pc+4, or the jump target for JAL/JALR.
    - retire_valid=1 next cycle with retire_pc=pc. instret += 1 (wraps at 2^CNT_W).
    - Go to FETCH.
  - EBREAK (0x00100073): no register write. halted=1, halt_cause=1, halt_pc=pc, exit_value=x10. Counts as retired (retire pulse, instret+1). Go to HALT.
  - Any other encoding, or register index >= NREGS: halt_cause=2, no write, no retire. Go to HALT.
  - JAL/JALR target with bit1 set (JALR clears bit0 first): halt_cause=3, no rd write, no retire. Go to HALT.
- HALT: terminal until reset. imem_req_valid=0, retire_valid=0, outputs frozen.
- Arithmetic:
  - All operations modulo 2^XLEN.
  - I/J/U immediates sign-extended to XLEN; the LUI result is sign-extended when XLEN=64.
- Throughput: minimum 3 cycles per instruction (FETCH->WAIT->EXEC) with zero-wait memory.

Decomposition:
- Package rv_core_pkg holds:
  - state enum {FETCH, WAIT, EXEC, HALT};
  - halt_cause enum;
  - opcode/funct3/funct7 constants (OP_IMM, OP, LUI, AUIPC, JAL, JALR, SYSTEM);
  - the EBREAK encoding.
- One sub-module, rv_mc_regfile (NREGS x XLEN):
  - 2 combinational read ports, 1 synchronous write port;
  - x0 hard-wired to 0;
  - async active-low clear.
- Decode, ALU and FSM stay in rv_mc_core.

Test Plan:
1. Release reset, req_ready=1 -> first imem_req_addr=0x80000000 with req_valid=1. Assert rst mid-WAIT -> pc returns to 0x80000000 and the late rsp_valid is ignored.
2. Fetch 0x00500093 (addi x1,x0,5), then 0x00108133 (add x2,x1,x1), zero-wait memory -> retire pulses 3 cycles apart, x2=10, instret=2.
3. Hold req_ready=0 for 4 cycles -> req_valid and addr stay stable; no retire until the response arrives.
4. Fetch 0x008000EF (jal x1,+8) at 0x80000000 -> next addr 0x80000008, x1=0x80000004. Fetch 0x00500013 (addi x0,x0,5) -> x0 stays 0.
5. Fetch 0x02A00513 (addi a0,x0,42), then 0x00100073 -> halted=1, halt_cause=1, exit_value=42, halt_pc=0x80000004, req_valid stays 0 afterwards.
6. Fetch 0x00000000 -> halt_cause=2, no retire pulse, instret unchanged. A JALR with odd target 0x80000003 -> halt_cause=3, rd unchanged.

Source files
------------

// File: rtl/rv_core_pkg.sv
// rv_core_pkg: shared states, halt causes and RV opcode constants for the multi-cycle core.
package rv_core_pkg;
    typedef enum logic [1:0] {FETCH, WAIT, EXEC, HALT} state_t;
    typedef enum logic [1:0] {HC_NONE, HC_EBREAK, HC_ILLEGAL, HC_MISALIGN} halt_cause_t;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
endpackage

// File: rtl/rv_mc_regfile.sv
// rv_mc_regfile: NREGS x XLEN register file, two combinational reads, one synchronous write, x0 fixed at zero.
module rv_mc_regfile #(
    parameter int XLEN = 64,
    parameter int NREGS = 32,
    localparam int AW = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   i_ra1,
    input  logic [AW-1:0]   i_ra2,
    input  logic            i_we,
    input  logic [AW-1:0]   i_wa,
    input  logic [XLEN-1:0] i_wd,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2
);
    logic [XLEN-1:0] r_mem [NREGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
        end else if (i_we && i_wa != '0) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == '0) ? '0 : r_mem[i_ra1];
    assign o_rd2 = (i_ra2 == '0) ? '0 : r_mem[i_ra2];
endmodule

// File: rtl/rv_mc_core.sv
// rv_mc_core: multi-cycle RV integer core (FETCH -> WAIT -> EXEC) over a valid/ready instruction port.
module rv_mc_core
    import rv_core_pkg::*;
#(
    parameter int          XLEN     = 64,
    parameter int          NREGS    = 32,
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic             retire_valid,
    output logic [XLEN-1:0]  retire_pc,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [XLEN-1:0]  halt_pc,
    output logic [XLEN-1:0]  exit_value
);
    localparam int AW = $clog2(NREGS);

    state_t          r_state, w_next;
    halt_cause_t     w_cause;
    logic [XLEN-1:0] r_pc, r_a0;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] w_rv1, w_rv2, w_imm_i, w_imm_j, w_imm_u, w_target, w_result, w_npc;
    logic            w_addi, w_add, w_sub, w_lui, w_auipc, w_jal, w_jalr, w_ebreak;
    logic            w_regs_ok, w_illegal, w_mis, w_exec, w_halt, w_retire, w_we;

    wire [6:0] w_op  = r_inst[6:0];
    wire [4:0] w_rd  = r_inst[11:7];
    wire [2:0] w_f3  = r_inst[14:12];
    wire [4:0] w_rs1 = r_inst[19:15];
    wire [4:0] w_rs2 = r_inst[24:20];
    wire [6:0] w_f7  = r_inst[31:25];

    function automatic logic idx_ok(input logic [4:0] idx);
        return 32'(idx) < NREGS;
    endfunction

    rv_mc_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk(clk), .rst(rst),
        .i_ra1(w_rs1[AW-1:0]), .i_ra2(w_rs2[AW-1:0]),
        .i_we(w_we), .i_wa(w_rd[AW-1:0]), .i_wd(w_result),
        .o_rd1(w_rv1), .o_rd2(w_rv2)
    );

    assign w_imm_i = XLEN'($signed(r_inst[31:20]));
    assign w_imm_j = XLEN'($signed({r_inst[31], r_inst[19:12], r_inst[20], r_inst[30:21], 1'b0}));
    assign w_imm_u = XLEN'($signed({r_inst[31:12], 12'b0}));

    assign w_addi   = w_op == OP_IMM && w_f3 == F3_ADD;
    assign w_add    = w_op == OP && w_f3 == F3_ADD && w_f7 == F7_ADD;
    assign w_sub    = w_op == OP && w_f3 == F3_ADD && w_f7 == F7_SUB;
    assign w_lui    = w_op == LUI;
    assign w_auipc  = w_op == AUIPC;
    assign w_jal    = w_op == JAL;
    assign w_jalr   = w_op == JALR && w_f3 == F3_ADD;
    assign w_ebreak = w_op == SYSTEM && r_inst == EBREAK;

    // Only the register fields an instruction actually uses are range-checked.
    assign w_regs_ok = idx_ok(w_rd) && (!(w_addi || w_add || w_sub || w_jalr) || idx_ok(w_rs1))
                       && (!(w_add || w_sub) || idx_ok(w_rs2));
    assign w_illegal = !w_ebreak && !((w_addi || w_add || w_sub || w_lui || w_auipc || w_jal || w_jalr) && w_regs_ok);
    assign w_target  = w_jal ? r_pc + w_imm_j : (w_rv1 + w_imm_i) & ~XLEN'(1);
    assign w_mis     = (w_jal || w_jalr) && w_target[1];
    assign w_cause   = w_illegal ? HC_ILLEGAL : w_ebreak ? HC_EBREAK : w_mis ? HC_MISALIGN : HC_NONE;
    assign w_exec    = r_state == EXEC;
    assign w_halt    = w_exec && w_cause != HC_NONE;
    assign w_retire  = w_exec && (w_cause == HC_NONE || w_cause == HC_EBREAK);
    assign w_we      = w_exec && w_cause == HC_NONE;

    assign w_result = w_addi  ? w_rv1 + w_imm_i :
                      w_add   ? w_rv1 + w_rv2 :
                      w_sub   ? w_rv1 - w_rv2 :
                      w_lui   ? w_imm_u :
                      w_auipc ? r_pc + w_imm_u : r_pc + XLEN'(4);
    assign w_npc = (w_jal || w_jalr) ? w_target : r_pc + XLEN'(4);

    assign imem_req_valid = r_state == FETCH;
    assign imem_req_addr  = r_pc;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            FETCH:   if (imem_req_ready) w_next = WAIT;
            WAIT:    if (imem_rsp_valid) w_next = EXEC;
            EXEC:    w_next = w_halt ? HALT : FETCH;
            default: w_next = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= FETCH;
        else      r_state <= w_next;
    end

    // r_a0 shadows x10 so exit_value needs no third register-file read port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc         <= XLEN'(RESET_PC);
            r_inst       <= '0;
            r_a0         <= '0;
            retire_valid <= 1'b0;
            retire_pc    <= '0;
            instret      <= '0;
            halted       <= 1'b0;
            halt_cause   <= HC_NONE;
            halt_pc      <= '0;
            exit_value   <= '0;
        end else begin
            retire_valid <= w_retire;
            if (r_state == WAIT && imem_rsp_valid) r_inst <= imem_rsp_data;
            if (w_we) r_pc <= w_npc;
            if (w_we && w_rd == 5'd10) r_a0 <= w_result;
            if (w_retire) begin
                retire_pc <= r_pc;
                instret   <= instret + 1'b1;
            end
            if (w_halt) begin
                halted     <= 1'b1;
                halt_cause <= w_cause;
                halt_pc    <= r_pc;
                exit_value <= r_a0;
            end
        end
    end
endmodule

// File: tb/tb_rv_mc_core.sv
// tb_rv_mc_core: scoreboard bench; expected retire PCs are queued as programs load and popped on each retire pulse.
module tb_rv_mc_core;
    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic        clk = 0, rst = 0, ready = 0, rsp_valid = 0;
    logic [31:0] rsp_data = 0;
    logic        req_valid, retire_valid, halted;
    logic [63:0] req_addr, retire_pc, instret, halt_pc, exit_value;
    logic [1:0]  halt_cause;

    int  checks = 0, errors = 0, cyc = 0, rsp_lat = 0;
    bit  auto_mem = 0;
    logic [31:0] mem [logic [63:0]];
    logic [63:0] exp_q [$];
    logic [63:0] fetch_q [$];
    int          rcyc_q [$];

    always #5 clk = ~clk;

    rv_mc_core dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_ready(ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .instret(instret),
        .halted(halted), .halt_cause(halt_cause), .halt_pc(halt_pc), .exit_value(exit_value)
    );

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    // memory model: accepts at the edge after a negedge sample of valid&ready, answers rsp_lat cycles later
    initial forever begin
        logic [63:0] fa;
        @(negedge clk);
        if (rst && auto_mem && req_valid && ready) begin
            fa = req_addr;
            fetch_q.push_back(fa);
            @(posedge clk);
            repeat (rsp_lat) @(posedge clk);
            #1 rsp_valid = 1;
            rsp_data = mem.exists(fa) ? mem[fa] : 32'h0;
            @(posedge clk);
            #1 rsp_valid = 0;
        end
    end

    initial forever begin
        logic [63:0] e;
        @(negedge clk);
        cyc++;
        if (rst && retire_valid) begin
            checks++;
            rcyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_retire pc=%h required=no retire", retire_pc);
            end else begin
                e = exp_q.pop_front();
                if (retire_pc !== e) begin
                    errors++;
                    $display("FAIL retire_pc got=%h want=%h", retire_pc, e);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    task automatic reset_core(input bit rdy);
        auto_mem = 0;
        ready = rdy;
        @(posedge clk);
        #1 rst = 0;
        exp_q.delete(); rcyc_q.delete(); fetch_q.delete(); mem.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    task automatic put(input logic [63:0] a, input logic [31:0] w, input bit retires);
        mem[a] = w;
        if (retires) exp_q.push_back(a);
    endtask

    task automatic wait_halt();
        int n = 0;
        while (halted !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_timeout halted=%b required=1", halted);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_core(1);
        @(negedge clk);
        checks++;
        if (req_valid !== 1'b1 || req_addr !== RST_PC) begin
            errors++;
            $display("FAIL first_fetch valid=%b addr=%h want valid=1 addr=%h", req_valid, req_addr, RST_PC);
        end
        checks++;
        if ({retire_valid, retire_pc, instret, halted, halt_cause, halt_pc, exit_value} !== '0) begin
            errors++;
            $display("FAIL reset_outputs rv=%b rpc=%h cnt=%h h=%b c=%0d hpc=%h ev=%h want all 0",
                     retire_valid, retire_pc, instret, halted, halt_cause, halt_pc, exit_value);
        end
        @(negedge clk);
        checks++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_req_valid got=%b want=0", req_valid);
        end
        rst = 0;
        ready = 0;
        #1;
        checks++;
        if (req_valid !== 1'b1 || req_addr !== RST_PC) begin
            errors++;
            $display("FAIL async_reset valid=%b addr=%h want valid=1 addr=%h", req_valid, req_addr, RST_PC);
        end
        @(posedge clk);
        #1 rst = 1;
        rsp_valid = 1;
        rsp_data = 32'h0;
        @(posedge clk);
        #1 rsp_valid = 0;
        @(negedge clk);
        checks++;
        if (halted !== 1'b0 || req_valid !== 1'b1 || req_addr !== RST_PC) begin
            errors++;
            $display("FAIL stale_rsp halted=%b valid=%b addr=%h want 0/1/%h", halted, req_valid, req_addr, RST_PC);
        end
    endtask

    task automatic test_back_to_back();
        reset_core(1);
        put(RST_PC,      32'h0050_0093, 1);
        put(RST_PC + 4,  32'h0010_8133, 1);
        put(RST_PC + 8,  enc_r(7'h00, 5'd0, 5'd2, 3'd0, 5'd10, 7'h33), 1);
        put(RST_PC + 12, EBRK, 1);
        auto_mem = 1;
        wait_halt();
        checks++;
        if (exit_value !== 64'd10 || instret !== 64'd4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_result ev=%0d cnt=%0d pending=%0d want 10/4/0", exit_value, instret, exp_q.size());
        end
        checks++;
        if (rcyc_q.size() != 4) begin
            errors++;
            $display("FAIL b2b_retire_count got=%0d want=4", rcyc_q.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (rcyc_q[i] - rcyc_q[i-1] != 3) begin
                    errors++;
                    $display("FAIL b2b_gap%0d got=%0d want=3", i, rcyc_q[i] - rcyc_q[i-1]);
                end
            end
        end
    endtask

    task automatic test_stall();
        reset_core(0);
        put(RST_PC,     enc_i(12'd7, 5'd0, 3'd0, 5'd10, 7'h13), 1);
        put(RST_PC + 4, EBRK, 1);
        auto_mem = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (req_valid !== 1'b1 || req_addr !== RST_PC || retire_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall%0d valid=%b addr=%h rv=%b want 1/%h/0", i, req_valid, req_addr, retire_valid, RST_PC);
            end
        end
        rsp_lat = 2;
        @(posedge clk);
        #1 ready = 1;
        wait_halt();
        rsp_lat = 0;
        checks++;
        if (exit_value !== 64'd7 || instret !== 64'd2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_result ev=%0d cnt=%0d pending=%0d want 7/2/0", exit_value, instret, exp_q.size());
        end
    endtask

    task automatic test_jal();
        reset_core(1);
        put(RST_PC,      32'h0080_00EF, 1);
        put(RST_PC + 8,  32'h0050_0013, 1);
        put(RST_PC + 12, enc_r(7'h00, 5'd0, 5'd1, 3'd0, 5'd10, 7'h33), 1);
        put(RST_PC + 16, EBRK, 1);
        auto_mem = 1;
        wait_halt();
        checks++;
        if (fetch_q.size() < 2 || fetch_q[1] !== RST_PC + 8) begin
            errors++;
            $display("FAIL jal_target got=%h want=%h", fetch_q.size() < 2 ? 64'hx : fetch_q[1], RST_PC + 8);
        end
        checks++;
        if (exit_value !== RST_PC + 4 || instret !== 64'd4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL jal_link ev=%h cnt=%0d pending=%0d want %h/4/0", exit_value, instret, exp_q.size(), RST_PC + 4);
        end
    endtask

    task automatic test_alu();
        logic [63:0] want = 64'hFFFF_FFFF_8000_0000 - 64'd2;
        reset_core(1);
        put(RST_PC,      enc_u(20'h0, 5'd5, 7'h17), 1);
        put(RST_PC + 4,  enc_i(12'd12, 5'd5, 3'd0, 5'd1, 7'h67), 1);
        put(RST_PC + 8,  32'h0, 0);
        put(RST_PC + 12, enc_r(7'h20, 5'd5, 5'd1, 3'd0, 5'd10, 7'h33), 1);
        put(RST_PC + 16, EBRK, 1);
        auto_mem = 1;
        wait_halt();
        checks++;
        if (exit_value !== 64'd8 || halt_cause !== 2'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL jalr_auipc ev=%h cause=%0d pending=%0d want 8/1/0", exit_value, halt_cause, exp_q.size());
        end
        reset_core(1);
        put(RST_PC,      enc_u(20'h80000, 5'd6, 7'h37), 1);
        put(RST_PC + 4,  enc_i(12'd3, 5'd0, 3'd0, 5'd1, 7'h13), 1);
        put(RST_PC + 8,  enc_i(12'd5, 5'd0, 3'd0, 5'd2, 7'h13), 1);
        put(RST_PC + 12, enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd7, 7'h33), 1);
        put(RST_PC + 16, enc_r(7'h00, 5'd7, 5'd6, 3'd0, 5'd10, 7'h33), 1);
        put(RST_PC + 20, EBRK, 1);
        auto_mem = 1;
        wait_halt();
        checks++;
        if (exit_value !== want || instret !== 64'd6) begin
            errors++;
            $display("FAIL lui_sub ev=%h cnt=%0d want %h/6", exit_value, instret, want);
        end
    endtask

    task automatic test_halt();
        reset_core(1);
        put(RST_PC,     32'h02A0_0513, 1);
        put(RST_PC + 4, EBRK, 1);
        auto_mem = 1;
        wait_halt();
        checks++;
        if (halt_cause !== 2'd1 || exit_value !== 64'd42 || halt_pc !== RST_PC + 4 || instret !== 64'd2) begin
            errors++;
            $display("FAIL ebreak cause=%0d ev=%0d hpc=%h cnt=%0d want 1/42/%h/2", halt_cause, exit_value, halt_pc, instret, RST_PC + 4);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (req_valid !== 1'b0 || retire_valid !== 1'b0 || instret !== 64'd2 || halted !== 1'b1) begin
                errors++;
                $display("FAIL frozen%0d valid=%b rv=%b cnt=%0d h=%b want 0/0/2/1", i, req_valid, retire_valid, instret, halted);
            end
        end
        reset_core(0);
        @(negedge clk);
        checks++;
        if (halted !== 1'b0 || halt_cause !== 2'd0 || instret !== 64'd0 || exit_value !== 64'd0) begin
            errors++;
            $display("FAIL reset_clears h=%b c=%0d cnt=%0d ev=%h want all 0", halted, halt_cause, instret, exit_value);
        end
    endtask

    task automatic test_illegal();
        reset_core(1);
        put(RST_PC,     enc_i(12'd3, 5'd0, 3'd0, 5'd10, 7'h13), 1);
        put(RST_PC + 4, 32'h0, 0);
        auto_mem = 1;
        wait_halt();
        checks++;
        if (halt_cause !== 2'd2 || halt_pc !== RST_PC + 4 || instret !== 64'd1 || exit_value !== 64'd3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL illegal cause=%0d hpc=%h cnt=%0d ev=%0d want 2/%h/1/3", halt_cause, halt_pc, instret, exit_value, RST_PC + 4);
        end
        reset_core(1);
        put(RST_PC,     enc_u(20'h0, 5'd5, 7'h17), 1);
        put(RST_PC + 4, enc_i(12'd9, 5'd0, 3'd0, 5'd10, 7'h13), 1);
        put(RST_PC + 8, enc_i(12'd3, 5'd5, 3'd0, 5'd10, 7'h67), 0);
        auto_mem = 1;
        wait_halt();
        checks++;
        if (halt_cause !== 2'd3 || halt_pc !== RST_PC + 8 || instret !== 64'd2 || exit_value !== 64'd9 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL misaligned cause=%0d hpc=%h cnt=%0d ev=%0d want 3/%h/2/9", halt_cause, halt_pc, instret, exit_value, RST_PC + 8);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_jal();
        test_alu();
        test_halt();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
